// File: rtl/spi_link_pkg.sv
// ---------------------------------------------------------------------------
// spi_link_pkg
// Shared constants and types for the sclk/dout/sync_n serial DAC link.
//   SPI_LEN   : bits per frame, MSB first
//   DATA_W    : payload width, frame bits DATA_W-1:0
//   NCH       : number of channel registers
//   ADDR_LSB  : lowest bit of the channel address field
//   ADDR_W    : width of the channel address field
//   BCAST_BIT : frame bit that requests a write to every channel
//   CNT_W     : width of the receive bit counter (must hold SPI_LEN)
//   rx_state_t: receiver FSM states
// ---------------------------------------------------------------------------
package spi_link_pkg;

   localparam int SPI_LEN   = 16;
   localparam int DATA_W    = 12;
   localparam int NCH       = 8;
   localparam int ADDR_LSB  = 12;
   localparam int ADDR_W    = 3;
   localparam int BCAST_BIT = 15;
   localparam int CNT_W     = $clog2(SPI_LEN + 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      DONE,
      WAIT_END,
      ERR
   } rx_state_t;

endpackage

// File: rtl/in_sync_edge.sv
// ---------------------------------------------------------------------------
// in_sync_edge
// Multi-flop synchronizer for one asynchronous input, followed by a history
// flop so that edges are detected on the synchronized value only.
//   clk_core : core clock
//   rst_n    : asynchronous active-low reset
//   d        : asynchronous input
//   level    : synchronized level
//   rise     : one-cycle pulse on a synchronized 0->1 transition
//   fall     : one-cycle pulse on a synchronized 1->0 transition
// RST_VAL is the idle level of the line, so that leaving reset does not
// produce a spurious edge.
// ---------------------------------------------------------------------------
module in_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk_core,
   input  logic rst_n,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   hist_reg;

   always_ff @(posedge clk_core or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= {SYNC_STAGES{RST_VAL}};
         hist_reg <= RST_VAL;
      end else begin
         sync_reg[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_reg[i] <= sync_reg[i-1];
         end
         hist_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign level = sync_reg[SYNC_STAGES-1];
   assign rise  = level & ~hist_reg;
   assign fall  = ~level & hist_reg;

endmodule

// File: rtl/spi_dac_frame_rx.sv
// ---------------------------------------------------------------------------
// spi_dac_frame_rx
// Slave-side receiver for the DAC serial link. sclk, din and sync_n are
// oversampled in the clk_core domain; MSB-first frames are shifted in on
// sclk falling edges and decoded into a channel register bank.
//   clk_core   : core clock
//   rst_n      : asynchronous active-low reset
//   en         : receive enable, only sampled when a frame starts
//   sclk       : serial clock, idles high
//   din        : serial data, sampled on sclk falling edge
//   sync_n     : frame select, active low
//   word_out   : last complete frame
//   word_valid : one-cycle pulse, new word_out
//   ch_data    : channel registers
//   ch_updated : one-cycle pulse per written channel
//   frame_err  : one-cycle pulse, short or overlong frame
//   busy       : high while a frame is in progress
//   frame_cnt  : number of good frames, wraps
// ---------------------------------------------------------------------------
module spi_dac_frame_rx
   import spi_link_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk_core,
   input  logic               rst_n,
   input  logic               en,
   input  logic               sclk,
   input  logic               din,
   input  logic               sync_n,
   output logic [SPI_LEN-1:0] word_out,
   output logic               word_valid,
   output logic [DATA_W-1:0]  ch_data [0:NCH-1],
   output logic [NCH-1:0]     ch_updated,
   output logic               frame_err,
   output logic               busy,
   output logic [15:0]        frame_cnt
);

   // ------------------------------------------------------------------
   // Input synchronizers
   // ------------------------------------------------------------------
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic sync_lvl, sync_rise, sync_fall;
   logic din_lvl, din_rise_unused, din_fall_unused;

   in_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
      .clk_core (clk_core),
      .rst_n    (rst_n),
      .d        (sclk),
      .level    (sclk_lvl),
      .rise     (sclk_rise),
      .fall     (sclk_fall)
   );

   in_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sync_n (
      .clk_core (clk_core),
      .rst_n    (rst_n),
      .d        (sync_n),
      .level    (sync_lvl),
      .rise     (sync_rise),
      .fall     (sync_fall)
   );

   in_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
      .clk_core (clk_core),
      .rst_n    (rst_n),
      .d        (din),
      .level    (din_lvl),
      .rise     (din_rise_unused),
      .fall     (din_fall_unused)
   );

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   rx_state_t            state_reg, state_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic [SPI_LEN-1:0]   shift_reg, shift_next;

   logic [SPI_LEN-1:0]   word_out_reg;
   logic                 word_valid_reg;
   logic [DATA_W-1:0]    ch_data_reg [0:NCH-1];
   logic [NCH-1:0]       ch_updated_reg;
   logic                 frame_err_reg;
   logic                 busy_reg;
   logic [15:0]          frame_cnt_reg;

   // True in the cycle the last bit of a frame is shifted in; the decode
   // works on shift_next so the outputs land exactly one cycle after the
   // final sclk falling edge is detected.
   logic                 frame_complete;
   logic                 bcast;
   logic [ADDR_W-1:0]    addr;
   logic [DATA_W-1:0]    payload;

   assign frame_complete = (state_reg == SHIFT) && (state_next == DONE);
   assign bcast          = shift_next[BCAST_BIT];
   assign addr           = shift_next[ADDR_LSB +: ADDR_W];
   assign payload        = shift_next[DATA_W-1:0];

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      shift_next = shift_reg;
      case (state_reg)
         IDLE: begin
            // An sclk edge coincident with the frame start is not a data bit.
            if (sync_fall && en) begin
               state_next = SHIFT;
               cnt_next   = '0;
               shift_next = '0;
            end
         end
         SHIFT: begin
            // sync_n rising wins over a coincident sclk edge.
            if (sync_rise) begin
               state_next = ERR;
            end else if (sclk_fall) begin
               shift_next = {shift_reg[SPI_LEN-2:0], din_lvl};
               cnt_next   = cnt_reg + 1'b1;
               if (cnt_reg == CNT_W'(SPI_LEN - 1)) begin
                  state_next = DONE;
               end
            end
         end
         DONE, WAIT_END: begin
            // DONE also watches the line so a frame end or extra clock
            // arriving during the decode cycle is not lost.
            if (sync_rise) begin
               state_next = IDLE;
            end else if (sclk_fall) begin
               state_next = ERR;
            end else begin
               state_next = WAIT_END;
            end
         end
         ERR: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_core or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         shift_reg      <= '0;
         word_out_reg   <= '0;
         word_valid_reg <= 1'b0;
         ch_updated_reg <= '0;
         frame_err_reg  <= 1'b0;
         busy_reg       <= 1'b0;
         frame_cnt_reg  <= '0;
         for (int i = 0; i < NCH; i++) begin
            ch_data_reg[i] <= '0;
         end
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         shift_reg      <= shift_next;
         word_valid_reg <= 1'b0;
         ch_updated_reg <= '0;
         frame_err_reg  <= (state_next == ERR);
         busy_reg       <= (state_next != IDLE);
         if (frame_complete) begin
            word_out_reg   <= shift_next;
            word_valid_reg <= 1'b1;
            frame_cnt_reg  <= frame_cnt_reg + 16'd1;
            for (int i = 0; i < NCH; i++) begin
               if (bcast || (addr == ADDR_W'(i))) begin
                  ch_data_reg[i]    <= payload;
                  ch_updated_reg[i] <= 1'b1;
               end
            end
         end
      end
   end

   assign word_out   = word_out_reg;
   assign word_valid = word_valid_reg;
   assign ch_data    = ch_data_reg;
   assign ch_updated = ch_updated_reg;
   assign frame_err  = frame_err_reg;
   assign busy       = busy_reg;
   assign frame_cnt  = frame_cnt_reg;

   // The synchronized levels of sclk and sync_n are only consumed through
   // their edge outputs.
   logic unused_levels;
   assign unused_levels = sclk_lvl ^ sync_lvl;

endmodule
